beacon_arbiter: RTL
===================

BEACON_ARBITER -- requirements
Module: beacon_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, fixed at 4 (2-bit ID field).
REQ-002 Parameter PREAMBLE_LEN, default 4: preamble bits per frame, range 2..15.
REQ-003 Parameter GAP_CYCLES, default 2: idle-low clocks after each frame, range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  level request per requester; held until its grant pulse.
REQ-007 data  input  8*NUM_REQ  byte per requester, requester i at bits [8i+7:8i]; sampled only at grant.
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse naming the requester whose byte is latched.
REQ-009 busy  output  1  high from the grant cycle through the last GAP cycle.
REQ-010 done  output  1  one-cycle pulse in the final clock of the parity bit.
REQ-011 signal  output  1  registered Manchester line driving the external delay line.

Function
REQ-012 States IDLE, PREAMBLE, ID, DATA, PARITY, GAP; each bit state holds two clocks per bit (half-phase h = 0, then 1).
REQ-013 Line encoding: signal = bit XOR h; bit 1 therefore produces 1 then 0, bit 0 produces 0 then 1.
REQ-014 IDLE: signal = 0, busy = 0; if any req is high, issue grant in that cycle, latch the winner's byte and ID, enter PREAMBLE next cycle.
REQ-015 Arbitration: round-robin starting at the index after the last granted requester; after reset, search starts at index 0.
REQ-016 PREAMBLE: PREAMBLE_LEN bits alternating, first bit 1.
REQ-017 ID: 2-bit requester index, MSB first.
REQ-018 DATA: latched byte, MSB first, 8 bits.
REQ-019 PARITY: one bit making the total count of ones over ID and data even.
REQ-020 done asserts in the h = 1 cycle of the parity bit; the next state is GAP.
REQ-021 GAP: signal = 0 for GAP_CYCLES clocks; requests are not granted during GAP; return to IDLE afterwards.
REQ-022 Frame length = 2*(PREAMBLE_LEN+11) clocks; default = 30 clocks of line activity plus 2 gap clocks.
REQ-023 Changes to req or data after grant do not affect the frame in flight.
REQ-024 Back-to-back requests: first grant is possible in the first IDLE cycle after GAP; no extra idle cycle is inserted.
REQ-025 A request deasserted before grant is dropped without side effects.
REQ-026 Bit and gap counters saturate at no value other than their terminal count and never wrap mid-state.

Reset
REQ-027 rst high on any edge: state = IDLE, signal = 0, grant = 0, busy = 0, done = 0, RR pointer selects index 0, counters = 0.
REQ-028 rst mid-frame aborts the frame immediately: no done pulse, and no GAP is inserted.
REQ-029 No output is X after the first reset edge.

Structure
REQ-030 A shared package holds the state enum, ID_W = 2, DATA_W = 8, and the fixed frame-field lengths.
REQ-031 One sub-module, manchester_tx, holds the bit shifter, half-phase toggle and registered signal; beacon_arbiter contains the arbiter and the FSM.
REQ-032 The delay line stays outside this block; signal feeds it directly.

Verification
REQ-033 Reset, then req = 0100 with data[23:16] = 0xA5 -> grant = 0100 one cycle.
  - Line bits: 1010 (preamble), 10 (ID), 10100101 (data), 1 (parity).
  - signal sequence starts 1,0,0,1,1,0,0,1.
  - done occurs 30 clocks after grant+1.
REQ-034 After reset, req = 1001 held -> grants in order 0001, 1000, 0001, with exactly 32 clocks between grant pulses.
REQ-035 data = 0x00 with ID 0 -> parity bit 0; signal shows 0,1 pairs for all 11 ID, data and parity bits.
REQ-036 Assert rst at clock 10 of a frame -> next cycle signal = 0 and busy = 0, no done pulse; a new request is granted to index 0 first.
REQ-037 Change data while busy -> transmitted byte equals the value sampled at grant; a req pulse during GAP only is never granted.

Source files
------------

// File: rtl/beacon_arbiter_pkg.sv
// Shared types and fixed frame-field widths for the beacon arbiter.
package beacon_arbiter_pkg;

  localparam int ID_W       = 2;
  localparam int DATA_W     = 8;
  localparam int PARITY_W   = 1;
  localparam int FIELD_BITS = ID_W + DATA_W + PARITY_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_ID,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  // Parity bit that makes the ones count over ID and data even.
  function automatic logic even_parity(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] byte_v);
    return ^{id, byte_v};
  endfunction

endpackage

// File: rtl/manchester_tx.sv
// Frame bit shifter, half-phase toggle and registered Manchester line output.
module manchester_tx #(
  parameter int FRAME_BITS = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  run,
  input  logic                  last,
  output logic                  h,
  output logic                  signal
);

  logic [FRAME_BITS-1:0] shreg;

  // The line register is loaded with the value for the coming cycle, so signal
  // lines up with the FSM state and half-phase that are active in that cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      // NOTE: the shifter is reset too, so no stale or X bit can ever reach the line.
      shreg  <= '0;
      h      <= 1'b0;
      signal <= 1'b0;
    end else if (load) begin
      shreg  <= frame;
      h      <= 1'b0;
      signal <= frame[FRAME_BITS-1];
    end else if (run) begin
      if (!h) begin
        h      <= 1'b1;
        signal <= ~shreg[FRAME_BITS-1];
      end else begin
        h      <= 1'b0;
        shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
        signal <= last ? 1'b0 : shreg[FRAME_BITS-2];
      end
    end else begin
      h      <= 1'b0;
      signal <= 1'b0;
    end
  end

endmodule

// File: rtl/beacon_arbiter.sv
// Round-robin requester arbiter and framing FSM feeding a Manchester line encoder.
module beacon_arbiter
  import beacon_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int PREAMBLE_LEN = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [8*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic                  done,
  output logic                  signal
);

  localparam int FRAME_BITS = PREAMBLE_LEN + FIELD_BITS;

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         win;
  logic                    found;
  logic                    grant_v;
  logic [DATA_W-1:0]       win_byte;
  logic [PREAMBLE_LEN-1:0] preamble;
  logic [FRAME_BITS-1:0]   frame;
  logic                    h;
  logic                    run;
  logic                    last;

  // Search starts at rr_ptr and wraps; first requesting index wins.
  always_comb begin : arb
    logic [ID_W-1:0] idx;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant_v  = !rst && (state == S_IDLE) && found;
  assign grant    = grant_v ? (NUM_REQ'(1) << win) : '0;
  assign busy     = !rst && ((state != S_IDLE) || grant_v);
  assign win_byte = data[DATA_W*win +: DATA_W];

  always_comb begin
    preamble = '0;
    for (int j = 0; j < PREAMBLE_LEN; j++) begin
      preamble[PREAMBLE_LEN-1-j] = (j % 2 == 0);
    end
  end

  assign frame = {preamble, win, win_byte, even_parity(win, win_byte)};
  assign run   = (state inside {S_PREAMBLE, S_ID, S_DATA, S_PARITY});
  assign last  = (state == S_PARITY) && h;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (grant_v) rr_ptr <= win + ID_W'(1);
    end
  end

  // Bit counters advance on the h = 1 half; each clears at its terminal count.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (grant_v) begin
          state_n = S_PREAMBLE;
          cnt_n   = '0;
        end
      end
      S_PREAMBLE: if (h) begin
        if (cnt == 4'(PREAMBLE_LEN - 1)) begin
          state_n = S_ID;
          cnt_n   = '0;
        end else cnt_n = cnt + 4'd1;
      end
      S_ID: if (h) begin
        if (cnt == 4'(ID_W - 1)) begin
          state_n = S_DATA;
          cnt_n   = '0;
        end else cnt_n = cnt + 4'd1;
      end
      S_DATA: if (h) begin
        if (cnt == 4'(DATA_W - 1)) begin
          state_n = S_PARITY;
          cnt_n   = '0;
        end else cnt_n = cnt + 4'd1;
      end
      S_PARITY: if (h) begin
        done    = !rst;
        state_n = S_GAP;
        cnt_n   = '0;
      end
      S_GAP: begin
        if (cnt == 4'(GAP_CYCLES - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + 4'd1;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  manchester_tx #(
    .FRAME_BITS(FRAME_BITS)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (grant_v),
    .frame  (frame),
    .run    (run),
    .last   (last),
    .h      (h),
    .signal (signal)
  );

endmodule
